// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: PC and instruction widths
// and the {pc, instr} entry passed from fetch to decode.
package fetch_pkg;

    localparam int PC_W = 16;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Synchronous FIFO with power-of-two depth, natural-wrap pointers,
// an occupancy count and a synchronous clear that keeps storage.
module fq_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 48,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: issues imem reads for the current pc, buffers
// returned {pc, instr} pairs and hands them to decode.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc,
    input  logic               flush,
    output logic               fetch_stall,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [PC_W-1:0]    dec_pc,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [CW-1:0]      count
);

    import fetch_pkg::*;

    localparam int EW = PC_W + INSTR_W;

    logic            inflight_q;
    logic [PC_W-1:0] req_pc_q;
    logic [CW:0]     credit;
    logic            full;
    logic            push;
    logic            pop;
    logic [EW-1:0]   head;

    // Credit ignores the current pop so stall never depends on dec_ready.
    assign credit = {1'b0, count} + (CW + 1)'(inflight_q);
    assign full   = credit >= (CW + 1)'(DEPTH);

    assign imem_req    = !rst && !flush && !full;
    assign fetch_stall = !rst && full;
    assign imem_addr   = pc;

    assign push      = inflight_q && !flush;
    assign dec_valid = !rst && !flush && (count != '0);
    assign pop       = dec_valid && dec_ready;

    assign dec_pc    = rst ? '0 : head[EW-1:INSTR_W];
    assign dec_instr = rst ? '0 : head[INSTR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            req_pc_q   <= '0;
        end else if (flush) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= imem_req;
            if (imem_req) begin
                req_pc_q <= pc;
            end
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({req_pc_q, imem_rdata}),
        .rdata (head),
        .count (count)
    );

endmodule
